rram_read_seq: RTL and testbench

RRAM_READ_SEQ -- requirements
Module: rram_read_seq

---
 rtl/rram_read_seq.sv | 216 +++++++++++++++++++++
 tb/tb_rram_read_seq.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rram_read_seq.sv
// RRAM read sequencer: precharge, line drive, current sensing, then three ADC channel captures.
// Optional feature macro RRAM_SEQ_ABORT_EN adds an ABORT input and a sticky ERR flag.
module rram_read_seq #(
    parameter int unsigned T_PRE   = 2,
    parameter int unsigned T_WL    = 3,
    parameter int unsigned T_SENSE = 2,
    parameter int unsigned T_ADC   = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        REQ,
    input  logic [3:0]  ROW,
    output logic        BUSY,
    output logic        DONE,
    output logic        PRE,
    output logic        ENABLE_WL,
    output logic        ENABLE_BL,
    output logic        ENABLE_SL,
    output logic [15:0] IN0_WL,
    output logic        ENABLE_CSA,
    output logic        SAEN_CSA,
    output logic        ENABLE_ADC,
    output logic [1:0]  CLK_EN_ADC,
    input  logic [15:0] ADC_OUT0,
    input  logic [15:0] ADC_OUT1,
    input  logic [15:0] ADC_OUT2,
    output logic [15:0] RES0,
    output logic [15:0] RES1,
    output logic [15:0] RES2
`ifdef RRAM_SEQ_ABORT_EN
    ,
    input  logic        ABORT,
    output logic        ERR
`endif
);

    localparam int unsigned CNT_W  = 8;
    localparam int unsigned CH_W   = 2;
    localparam int unsigned ROW_W  = 4;
    localparam int unsigned DATA_W = 16;

    localparam logic [CNT_W-1:0] LD_PRE   = CNT_W'(T_PRE - 1);
    localparam logic [CNT_W-1:0] LD_WL    = CNT_W'(T_WL - 1);
    localparam logic [CNT_W-1:0] LD_SENSE = CNT_W'(T_SENSE - 1);
    localparam logic [CNT_W-1:0] LD_ADC   = CNT_W'(T_ADC - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_PRECH, S_DRIVE, S_SENSE, S_CONV, S_DONE
    } state_t;

    state_t              state, state_nxt;
    logic [CNT_W-1:0]    cnt, cnt_nxt;
    logic [CH_W-1:0]     ch, ch_nxt;
    logic [ROW_W-1:0]    row, row_nxt;
    logic [DATA_W-1:0]   res0_nxt, res1_nxt, res2_nxt;
    logic                accept;
    logic                abort_hit;
    logic                busy_nxt, done_nxt, pre_nxt, wl_nxt, csa_nxt, saen_nxt, adc_nxt;
    logic [DATA_W-1:0]   in0_wl_nxt;
    logic [CH_W-1:0]     clk_en_nxt;

`ifdef RRAM_SEQ_ABORT_EN
    assign abort_hit = ABORT && (state != S_IDLE);
`else
    assign abort_hit = 1'b0;
`endif

    // Next-state, capture and Moore decode of the next state so outputs line up with the state
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        ch_nxt    = ch;
        row_nxt   = row;
        res0_nxt  = RES0;
        res1_nxt  = RES1;
        res2_nxt  = RES2;
        accept    = 1'b0;

        case (state)
            S_IDLE:  accept = REQ;
            S_PRECH: begin
                if (cnt == '0) begin
                    state_nxt = S_DRIVE;
                    cnt_nxt   = LD_WL;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            S_DRIVE: begin
                if (cnt == '0) begin
                    state_nxt = S_SENSE;
                    cnt_nxt   = LD_SENSE;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            S_SENSE: begin
                if (cnt == '0) begin
                    state_nxt = S_CONV;
                    cnt_nxt   = LD_ADC;
                    ch_nxt    = '0;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            S_CONV: begin
                if (cnt == '0) begin
                    case (ch)
                        2'd0:    res0_nxt = ADC_OUT0;
                        2'd1:    res1_nxt = ADC_OUT1;
                        default: res2_nxt = ADC_OUT2;
                    endcase
                    if (ch == 2'd2) begin
                        state_nxt = S_DONE;
                    end else begin
                        ch_nxt  = ch + CH_W'(1);
                        cnt_nxt = LD_ADC;
                    end
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            // DONE is not busy, so a held REQ restarts without an idle bubble
            S_DONE: begin
                state_nxt = S_IDLE;
                accept    = REQ;
            end
            default: state_nxt = S_IDLE;
        endcase

        if (accept) begin
            state_nxt = S_PRECH;
            cnt_nxt   = LD_PRE;
            ch_nxt    = '0;
            row_nxt   = ROW;
        end

        if (abort_hit) begin
            state_nxt = S_IDLE;
            cnt_nxt   = '0;
            ch_nxt    = '0;
            row_nxt   = row;
            res0_nxt  = RES0;
            res1_nxt  = RES1;
            res2_nxt  = RES2;
        end

        busy_nxt   = (state_nxt == S_PRECH) || (state_nxt == S_DRIVE) ||
                     (state_nxt == S_SENSE) || (state_nxt == S_CONV);
        done_nxt   = (state_nxt == S_DONE);
        pre_nxt    = (state_nxt == S_PRECH);
        wl_nxt     = (state_nxt == S_DRIVE) || (state_nxt == S_SENSE);
        in0_wl_nxt = wl_nxt ? (DATA_W'(1) << row_nxt) : '0;
        csa_nxt    = (state_nxt == S_SENSE) || (state_nxt == S_CONV);
        saen_nxt   = (state_nxt == S_SENSE) && (cnt_nxt == '0);
        adc_nxt    = (state_nxt == S_CONV);
        clk_en_nxt = adc_nxt ? (ch_nxt + CH_W'(1)) : '0;
    end

    // State register and registered outputs
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= S_IDLE;
            cnt        <= '0;
            ch         <= '0;
            row        <= '0;
            BUSY       <= 1'b0;
            DONE       <= 1'b0;
            PRE        <= 1'b0;
            ENABLE_WL  <= 1'b0;
            ENABLE_BL  <= 1'b0;
            ENABLE_SL  <= 1'b0;
            IN0_WL     <= '0;
            ENABLE_CSA <= 1'b0;
            SAEN_CSA   <= 1'b0;
            ENABLE_ADC <= 1'b0;
            CLK_EN_ADC <= '0;
            RES0       <= '0;
            RES1       <= '0;
            RES2       <= '0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            ch         <= ch_nxt;
            row        <= row_nxt;
            BUSY       <= busy_nxt;
            DONE       <= done_nxt;
            PRE        <= pre_nxt;
            ENABLE_WL  <= wl_nxt;
            ENABLE_BL  <= wl_nxt;
            ENABLE_SL  <= wl_nxt;
            IN0_WL     <= in0_wl_nxt;
            ENABLE_CSA <= csa_nxt;
            SAEN_CSA   <= saen_nxt;
            ENABLE_ADC <= adc_nxt;
            CLK_EN_ADC <= clk_en_nxt;
            RES0       <= res0_nxt;
            RES1       <= res1_nxt;
            RES2       <= res2_nxt;
        end
    end

`ifdef RRAM_SEQ_ABORT_EN
    // Sticky abort flag, cleared by the next accepted request
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ERR <= 1'b0;
        end else if (abort_hit) begin
            ERR <= 1'b1;
        end else if (accept) begin
            ERR <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_rram_read_seq.sv
// Scoreboard bench for rram_read_seq: elapsed-time reference model checks every output each cycle.
module tb_rram_read_seq;

    localparam int TP   = 2;
    localparam int TW   = 3;
    localparam int TS   = 2;
    localparam int TA   = 4;
    localparam int B    = TP + TW + TS;
    localparam int LAT  = B + 3 * TA;
    localparam int HIST = 4096;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic [3:0]  row = 4'd0;
    logic [15:0] adc0 = '0, adc1 = '0, adc2 = '0;
    logic        busy, done, pre, en_wl, en_bl, en_sl, en_csa, saen, en_adc;
    logic [15:0] in0_wl, res0, res1, res2;
    logic [1:0]  clk_en;

    logic        req1 = 1'b0;
    logic        busy1, done1, pre1, wl1, bl1, sl1, csa1, saen1, adc_en1;
    logic [15:0] in0_wl1, r10, r11, r12;
    logic [1:0]  clk_en1;

`ifdef RRAM_SEQ_ABORT_EN
    logic abort = 1'b0;
    logic err, err1;
`endif

    rram_read_seq #(.T_PRE(TP), .T_WL(TW), .T_SENSE(TS), .T_ADC(TA)) dut (
        .CLK(clk), .RST(rst), .REQ(req), .ROW(row),
        .BUSY(busy), .DONE(done), .PRE(pre),
        .ENABLE_WL(en_wl), .ENABLE_BL(en_bl), .ENABLE_SL(en_sl),
        .IN0_WL(in0_wl), .ENABLE_CSA(en_csa), .SAEN_CSA(saen),
        .ENABLE_ADC(en_adc), .CLK_EN_ADC(clk_en),
        .ADC_OUT0(adc0), .ADC_OUT1(adc1), .ADC_OUT2(adc2),
        .RES0(res0), .RES1(res1), .RES2(res2)
`ifdef RRAM_SEQ_ABORT_EN
        , .ABORT(abort), .ERR(err)
`endif
    );

    rram_read_seq #(.T_PRE(1), .T_WL(1), .T_SENSE(1), .T_ADC(1)) dut1 (
        .CLK(clk), .RST(rst), .REQ(req1), .ROW(4'd3),
        .BUSY(busy1), .DONE(done1), .PRE(pre1),
        .ENABLE_WL(wl1), .ENABLE_BL(bl1), .ENABLE_SL(sl1),
        .IN0_WL(in0_wl1), .ENABLE_CSA(csa1), .SAEN_CSA(saen1),
        .ENABLE_ADC(adc_en1), .CLK_EN_ADC(clk_en1),
        .ADC_OUT0(16'hAAAA), .ADC_OUT1(16'hBBBB), .ADC_OUT2(16'hCCCC),
        .RES0(r10), .RES1(r11), .RES2(r12)
`ifdef RRAM_SEQ_ABORT_EN
        , .ABORT(1'b0), .ERR(err1)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         a;
        logic [3:0] row;
    } txn_t;

    txn_t        sb_q[$];
    logic [15:0] hist [3][HIST];
    logic [15:0] exp_res [3];
    logic        exp_err = 1'b0;
    int          next_free = 0;
    int          abort_edge = -1;
    int          errors = 0;
    int          checks = 0;

    task automatic chk(input string name, input logic [74:0] act, input logic [74:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at edge %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [74:0] outs();
        return {busy, done, pre, en_wl, en_bl, en_sl, in0_wl, en_csa, saen, en_adc, clk_en,
                res0, res1, res2};
    endfunction

    // Called at a falling edge: drives inputs for the next rising edge and models acceptance
    task automatic drive(input bit r, input logic [3:0] rw,
                         input logic [15:0] a0, input logic [15:0] a1, input logic [15:0] a2);
        int   e;
        txn_t tx;
        e    = cyc + 1;
        req  = r;
        row  = rw;
        adc0 = a0;
        adc1 = a1;
        adc2 = a2;
        hist[0][e % HIST] = a0;
        hist[1][e % HIST] = a1;
        hist[2][e % HIST] = a2;
        if (r && !rst && e >= next_free) begin
            tx.a   = e;
            tx.row = rw;
            sb_q.push_back(tx);
            next_free = e + LAT + 1;
        end
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        drive(1'b0, 4'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
    endtask

    task automatic sample();
        int          n, t;
        bit          act;
        txn_t        tmp;
        logic [3:0]  r;
        logic        e_busy, e_done, e_pre, e_wl, e_csa, e_saen, e_adc;
        logic [1:0]  e_ce;
        logic [15:0] e_vec;
        n = cyc;
        if (rst) begin
            sb_q.delete();
            for (int k = 0; k < 3; k++) exp_res[k] = '0;
            exp_err = 1'b0;
            chk("reset_state", outs(), '0);
            return;
        end
        if (n == abort_edge && sb_q.size() > 0) begin
            tmp = sb_q.pop_front();
            exp_err = 1'b1;
        end
        act = (sb_q.size() > 0) && (n >= sb_q[0].a);
        t   = act ? n - sb_q[0].a : 0;
        r   = act ? sb_q[0].row : 4'd0;
        if (act && t == 0) exp_err = 1'b0;
        for (int k = 0; k < 3; k++)
            if (act && t == B + (k + 1) * TA) exp_res[k] = hist[k][n % HIST];
        e_busy = act && t < LAT;
        e_done = act && t == LAT;
        e_pre  = act && t < TP;
        e_wl   = act && t >= TP && t < B;
        e_csa  = act && t >= TP + TW && t < LAT;
        e_saen = act && t == B - 1;
        e_adc  = act && t >= B && t < LAT;
        e_ce   = e_adc ? 2'((t - B) / TA + 1) : 2'd0;
        e_vec  = e_wl ? (16'd1 << r) : 16'd0;
        chk("outputs", outs(), {e_busy, e_done, e_pre, e_wl, e_wl, e_wl, e_vec, e_csa, e_saen,
                                e_adc, e_ce, exp_res[0], exp_res[1], exp_res[2]});
`ifdef RRAM_SEQ_ABORT_EN
        chk("err", 75'(err), 75'(exp_err));
`endif
        if (done === 1'b1) begin
            if (act) begin
                chk("done_latency", 75'(t), 75'(LAT));
                tmp = sb_q.pop_front();
            end else begin
                checks++;
                errors++;
                $display("FAIL done_unexpected at edge %0d: got 1 expected 0", n);
            end
        end else if (act && t >= LAT) begin
            checks++;
            errors++;
            $display("FAIL done_missing at edge %0d: got 0 expected 1", n);
            tmp = sb_q.pop_front();
        end
    endtask

    initial begin : monitor
        for (int k = 0; k < 3; k++) exp_res[k] = '0;
        forever begin
            @(posedge clk);
            #1;
            sample();
        end
    end

    // All-ones timing instance: one request, latency and pulse widths
    initial begin : short_timing
        int a1, done_at, pre_n, saen_n, done_n;
        done_at = -1;
        pre_n   = 0;
        saen_n  = 0;
        done_n  = 0;
        repeat (8) @(negedge clk);
        req1 = 1'b1;
        a1   = cyc + 1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            req1 = 1'b0;
            if (pre1)  pre_n++;
            if (saen1) saen_n++;
            if (done1) begin
                done_n++;
                if (done_at < 0) done_at = cyc;
            end
        end
        chk("t1_latency", 75'(done_at - a1), 75'(6));
        chk("t1_pre_cycles", 75'(pre_n), 75'(1));
        chk("t1_saen_cycles", 75'(saen_n), 75'(1));
        chk("t1_done_pulses", 75'(done_n), 75'(1));
    end

    initial begin : stim
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            drive(1'b0, 4'd0, '0, '0, '0);
        end
        // Single request on row 5 with constant ADC values
        @(negedge clk);
        rst = 1'b0;
        drive(1'b1, 4'd5, 16'h1111, 16'h2222, 16'h3333);
        repeat (LAT + 3) begin
            @(negedge clk);
            drive(1'b0, 4'($urandom), 16'h1111, 16'h2222, 16'h3333);
        end
        chk("res_const", 75'({res0, res1, res2}), 75'({16'h1111, 16'h2222, 16'h3333}));

        // REQ held high: back-to-back requests, row changes while busy
        repeat (3 * (LAT + 1)) begin
            @(negedge clk);
            drive(1'b1, 4'($urandom), 16'h1111, 16'h2222, 16'h3333);
        end

        // Random requests and per-cycle random ADC values
        repeat (1200) begin
            @(negedge clk);
            drive($urandom_range(0, 3) == 0, 4'($urandom),
                  16'($urandom), 16'($urandom), 16'($urandom));
        end

        // Reset while converting channel 1
        while (cyc + 1 < next_free) idle_cycle();
        @(negedge clk);
        drive(1'b1, 4'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
        repeat (B + TA + 1) idle_cycle();
        @(negedge clk);
        chk("ch1_before_reset", 75'(clk_en), 75'(2));
        rst = 1'b1;
        drive(1'b0, 4'd0, 16'($urandom), 16'($urandom), 16'($urandom));
        #1;
        chk("async_reset", outs(), '0);
        repeat (2) idle_cycle();
        @(negedge clk);
        rst = 1'b0;
        next_free = 0;
        drive(1'b1, 4'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));

        repeat (300) begin
            @(negedge clk);
            drive($urandom_range(0, 2) == 0, 4'($urandom),
                  16'($urandom), 16'($urandom), 16'($urandom));
        end

`ifdef RRAM_SEQ_ABORT_EN
        // Abort in DRIVE, then a clean request
        while (cyc + 1 < next_free) idle_cycle();
        @(negedge clk);
        drive(1'b1, 4'd9, 16'($urandom), 16'($urandom), 16'($urandom));
        repeat (TP + 1) idle_cycle();
        @(negedge clk);
        abort = 1'b1;
        abort_edge = cyc + 1;
        drive(1'b0, 4'd0, 16'($urandom), 16'($urandom), 16'($urandom));
        next_free = abort_edge + 1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_wl_off", 75'(en_wl), 75'(0));
        chk("abort_err_set", 75'(err), 75'(1));
        drive(1'b1, 4'd2, 16'($urandom), 16'($urandom), 16'($urandom));
`endif

        repeat (LAT + 4) idle_cycle();
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: got %0d pending expected 0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
